ext_spi_master: RTL and testbench
=================================

// Module: ext_spi_master
// PURPOSE
//  SPI initiator for the ext card's register link. Sends one 16-bit frame per command to the ext CPLD:
//  bits[10:8] select the target register, bits[7:0] carry the data, bits[15:11] are 0.
//  In the same frame it captures the CPLD's reply {8'hEE, bus snapshot}. Sits in the controller FPGA/MCU-side
//  fabric, between a command/response handshake and the sck/ss_n/mosi/miso pins.
// PARAMETERS
//  CLK_DIV   4  clk cycles per sck half-period; legal range >=2
//  GAP_CYC   8  minimum clk cycles ss_n stays high between frames; legal range >=1
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  asynchronous reset, active-high
//  cmd_valid  in   1  command request
//  cmd_ready  out  1  block can accept a command
//  cmd_reg    in   3  register number: 0=fadf, 1=fbdf, 2=ffdf, 3=wait ctrl, 4..7=no-op (read-only)
//  cmd_data   in   8  data for the register (wait ctrl: bit0 = 1 forces wait_n low)
//  rsp_valid  out  1  one-clk pulse when a frame completes
//  rsp_data   out  8  low byte of the captured reply (CPLD bus snapshot)
//  rsp_sync   out  1  1 when the captured high byte == 8'hEE (link alive)
//  busy       out  1  frame or gap in progress
//  sck        out  1  SPI clock, idles 0
//  ss_n       out  1  slave select, active-low
//  mosi       out  1  master data out
//  miso       in   1  slave data out, already synchronous to the sck the block generates
// BEHAVIOUR
//  Reset values: cmd_ready=0 while rst is high and 1 from the first clk edge after rst is released.
//   sck=0, ss_n=1, mosi=0, rsp_valid=0, rsp_data=0, rsp_sync=0, busy=0.
//  Async reset: rst forces sck=0 and ss_n=1 immediately.
//   The slave commits on any ss_n rise, so a reset mid-frame may commit a partial frame. Accepted hazard.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//   IDLE: cmd_ready=1. A command is accepted at clk edge T0 when cmd_valid & cmd_ready.
//    At T0 the block latches word W = {5'b0, cmd_reg, cmd_data} and clears the capture register.
//   SETUP: at T0+1 ss_n=0 and mosi=W[15]; sck is still 0. Lasts CLK_DIV cycles.
//   SHIFT: 16 sck pulses, each half-period CLK_DIV clks.
//    Rise k (k=1..16) at T0+1+(2k-1)*CLK_DIV; fall k at T0+1+2k*CLK_DIV.
//    At rise k, mosi <= W[16-k]. The slave samples mosi on the falling edge.
//    On the clk edge that drives fall k, the block shifts miso into the capture register (MSB first).
//   HOLD: after fall 16, sck=0 and ss_n stays low for CLK_DIV cycles.
//    At T0+1+33*CLK_DIV: ss_n=1, mosi=0, rsp_valid=1 for one clk, rsp_data=cap[7:0], rsp_sync=(cap[15:8]==8'hEE).
//    rsp_data and rsp_sync hold until the next frame completes.
//   GAP: ss_n stays high for GAP_CYC cycles, then IDLE with cmd_ready=1.
//  Default timing (CLK_DIV=4, GAP_CYC=8): ss_n low T0+1..T0+132, high at T0+133, next accept at T0+141 at earliest.
//  cmd_ready=0 and busy=1 in every state except IDLE. cmd_* inputs are ignored outside IDLE.
//  cmd_valid held high gives back-to-back frames separated by exactly GAP_CYC+1 ss_n-high clks.
//  cmd_reg 4..7: the frame is still fully clocked. The slave ignores the write, and the reply still returns the bus snapshot.
//  sck never toggles while ss_n=1. ss_n never changes while sck=1.
//  Divider counter width is clog2(CLK_DIV); the bit counter is 5 bits and covers 0..16.
// TESTING
//  1 Write: cmd_reg=0, cmd_data=8'h5A -> 16 bits sampled on sck falls = 16'h005A; ss_n low 132 clks; rsp_valid pulses once.
//  2 Read: slave model returns {8'hEE, 8'h3C}, cmd_reg=5 -> mosi word 16'h0500; rsp_data=8'h3C, rsp_sync=1.
//  3 Dead link: miso stuck at 1 -> rsp_data=8'hFF, rsp_sync=0.
//  4 Back-to-back: cmd_valid held for 3 cmds (reg 1/8'hAA, 2/8'h01, 3/8'h01) -> 3 frames 16'h01AA, 16'h0201, 16'h0301; each ss_n-high gap = 9 clks.
//  5 Reset at fall 7 of a frame -> ss_n=1 and sck=0 in the same timestep; after release, IDLE with cmd_ready=1 and no rsp_valid.
//  6 CLK_DIV=2: frame 16'h0077 -> sck period 4 clks; rsp_valid at T0+67.

Source files
------------

// File: rtl/ext_spi_master.sv
// SPI initiator for the ext CPLD register link: one 16-bit frame {5'b0, reg, data} per command,
// capturing the CPLD reply {8'hEE, bus snapshot} in the same frame.
module ext_spi_master #(
   parameter int CLK_DIV = 4,
   parameter int GAP_CYC = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_reg,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_sync,
   output logic       busy,
   output logic       sck,
   output logic       ss_n,
   output logic       mosi,
   input  logic       miso
);

   localparam int DW = $clog2(CLK_DIV);
   localparam int GW = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC >= 2) ? (GAP_CYC - 2) : 0);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t          state;
   logic [DW-1:0]   div_cnt;
   logic [GW-1:0]   gap_cnt;
   logic [4:0]      bit_cnt;
   logic [15:0]     sh;
   logic [15:0]     cap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         div_cnt   <= '0;
         gap_cnt   <= '0;
         bit_cnt   <= '0;
         sh        <= '0;
         cap       <= '0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_sync  <= 1'b0;
         busy      <= 1'b0;
         sck       <= 1'b0;
         ss_n      <= 1'b1;
         mosi      <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  sh        <= {5'b0, cmd_reg, cmd_data};
                  cap       <= '0;
                  bit_cnt   <= '0;
                  div_cnt   <= '0;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= SETUP;
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            // First SETUP cycle drops ss_n; the divider then runs one half-period before rise 1.
            SETUP: begin
               if (ss_n) begin
                  ss_n    <= 1'b0;
                  mosi    <= sh[15];
                  div_cnt <= '0;
               end else if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  sck     <= 1'b1;
                  mosi    <= sh[15];
                  sh      <= {sh[14:0], 1'b0};
                  state   <= SHIFT;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (sck) begin
                     sck     <= 1'b0;
                     cap     <= {cap[14:0], miso};
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd15)
                        state <= HOLD;
                  end else begin
                     sck  <= 1'b1;
                     mosi <= sh[15];
                     sh   <= {sh[14:0], 1'b0};
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            HOLD: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt   <= '0;
                  gap_cnt   <= '0;
                  ss_n      <= 1'b1;
                  mosi      <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_data  <= cap[7:0];
                  rsp_sync  <= (cap[15:8] == 8'hEE);
                  if (GAP_CYC <= 1) begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     cmd_ready <= 1'b1;
                  end else begin
                     state <= GAP;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            // The HOLD exit cycle already counts as the first ss_n-high cycle.
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ext_spi_master.sv
// Bench for ext_spi_master: SPI slave model per instance, cycle-stamped pin monitor, scenario tasks.
module tb_ext_spi_master;
   localparam int C  = 4;
   localparam int G  = 8;
   localparam int C2 = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   logic       cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_sync, busy, sck, ss_n, mosi;
   logic [2:0] cmd_reg = '0;
   logic [7:0] cmd_data = '0, rsp_data;
   logic       miso = 1'b0;

   logic       cmd_valid2 = 1'b0, cmd_ready2, rsp_valid2, rsp_sync2, busy2, sck2, ss_n2, mosi2;
   logic [2:0] cmd_reg2 = '0;
   logic [7:0] cmd_data2 = '0, rsp_data2;
   logic       miso2 = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ext_spi_master #(.CLK_DIV(C), .GAP_CYC(G)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_reg(cmd_reg),
      .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_sync(rsp_sync),
      .busy(busy), .sck(sck), .ss_n(ss_n), .mosi(mosi), .miso(miso));

   ext_spi_master #(.CLK_DIV(C2), .GAP_CYC(G)) dut2 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_reg(cmd_reg2),
      .cmd_data(cmd_data2), .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .rsp_sync(rsp_sync2),
      .busy(busy2), .sck(sck2), .ss_n(ss_n2), .mosi(mosi2), .miso(miso2));

   // Slave models: drive reply MSB first on sck rise, sample mosi on sck fall.
   logic [15:0] reply = '0, rx = '0;
   int          nb = 0, idx = 0;
   logic        p_ss = 1'b1, p_sck = 1'b0;
   logic [15:0] frames[$];
   int          fbits[$];
   always @(ss_n or sck) begin
      if (p_ss === 1'b1 && ss_n === 1'b0) begin rx = '0; nb = 0; idx = 0; end
      if (p_sck === 1'b0 && sck === 1'b1) begin
         miso = (idx < 16) ? reply[15 - idx] : 1'b0;
         idx++;
      end
      if (p_sck === 1'b1 && sck === 1'b0 && ss_n === 1'b0) begin rx = {rx[14:0], mosi}; nb++; end
      if (p_ss === 1'b0 && ss_n === 1'b1) begin frames.push_back(rx); fbits.push_back(nb); miso = 1'b0; end
      p_ss = ss_n;
      p_sck = sck;
   end

   logic [15:0] reply2 = '0, rx2 = '0, rx2_done = '0;
   int          nb2 = 0, idx2 = 0, nb2_done = 0;
   logic        p_ss2 = 1'b1, p_sck2 = 1'b0;
   always @(ss_n2 or sck2) begin
      if (p_ss2 === 1'b1 && ss_n2 === 1'b0) begin rx2 = '0; nb2 = 0; idx2 = 0; end
      if (p_sck2 === 1'b0 && sck2 === 1'b1) begin
         miso2 = (idx2 < 16) ? reply2[15 - idx2] : 1'b0;
         idx2++;
      end
      if (p_sck2 === 1'b1 && sck2 === 1'b0 && ss_n2 === 1'b0) begin rx2 = {rx2[14:0], mosi2}; nb2++; end
      if (p_ss2 === 1'b0 && ss_n2 === 1'b1) begin rx2_done = rx2; nb2_done = nb2; miso2 = 1'b0; end
      p_ss2 = ss_n2;
      p_sck2 = sck2;
   end

   // Pin monitors, sampled 1 time unit after each rising edge; cyc is that edge's index.
   int   falls[$], rises[$];
   int   rsp_cnt = 0, rsp_cyc = 0, viol = 0;
   logic m_ss = 1'b1, m_sck = 1'b0;
   int   sck2_rises[$];
   int   rsp_cnt2 = 0, rsp_cyc2 = 0, fall2 = 0, rise2 = 0;
   logic m_ss2 = 1'b1, m_sck2 = 1'b0;
   always @(posedge clk) begin
      #1;
      if (m_ss && !ss_n) falls.push_back(cyc);
      if (!m_ss && ss_n) rises.push_back(cyc);
      if (rsp_valid) begin rsp_cnt++; rsp_cyc = cyc; end
      if (ss_n && sck) viol++;
      if ((ss_n !== m_ss) && (sck || m_sck)) viol++;
      m_ss = ss_n;
      m_sck = sck;
      if (m_ss2 && !ss_n2) fall2 = cyc;
      if (!m_ss2 && ss_n2) rise2 = cyc;
      if (sck2 && !m_sck2) sck2_rises.push_back(cyc);
      if (rsp_valid2) begin rsp_cnt2++; rsp_cyc2 = cyc; end
      m_ss2 = ss_n2;
      m_sck2 = sck2;
   end

   task automatic send(input logic [2:0] r, input logic [7:0] d, output int t0);
      int k = 0;
      @(negedge clk);
      cmd_reg = r; cmd_data = d; cmd_valid = 1'b1;
      while (cmd_ready !== 1'b1 && k < 400) begin @(negedge clk); k++; end
      if (k >= 400) begin checks++; errors++; $display("FAIL accept_timeout cmd_ready=%b required 1", cmd_ready); end
      t0 = cyc + 1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int c0, output int ready_cyc);
      int k = 0;
      while (rsp_cnt == c0 && k < 1000) begin @(negedge clk); k++; end
      if (k >= 1000) begin checks++; errors++; $display("FAIL rsp_timeout rsp_cnt=%0d required >%0d", rsp_cnt, c0); end
      k = 0;
      while (cmd_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
      if (k >= 100) begin checks++; errors++; $display("FAIL idle_timeout cmd_ready=%b required 1", cmd_ready); end
      ready_cyc = cyc;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({cmd_ready, sck, ss_n, mosi, rsp_valid, rsp_sync, busy} !== 7'b0010000)
         begin errors++; $display("FAIL reset_ctrl got ready/sck/ss_n/mosi/vld/sync/busy=%b required 0010000",
                                  {cmd_ready, sck, ss_n, mosi, rsp_valid, rsp_sync, busy}); end
      checks++;
      if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %h required 00", rsp_data); end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({cmd_ready, busy} !== 2'b10) begin errors++; $display("FAIL post_reset_ready got ready/busy=%b required 10", {cmd_ready, busy}); end
   endtask

   task automatic test_write;
      int t0, rc, c0;
      reply = 16'hEE12;
      frames.delete(); fbits.delete(); falls.delete(); rises.delete();
      c0 = rsp_cnt;
      send(3'd0, 8'h5A, t0);
      checks++;
      if ({busy, cmd_ready, ss_n} !== 3'b101) begin errors++; $display("FAIL write_accept got busy/ready/ss_n=%b required 101", {busy, cmd_ready, ss_n}); end
      @(negedge clk);
      checks++;
      if ({ss_n, sck, mosi} !== 3'b000) begin errors++; $display("FAIL write_setup got ss_n/sck/mosi=%b required 000", {ss_n, sck, mosi}); end
      wait_done(c0, rc);
      checks++;
      if (frames.size() != 1 || frames[0] !== 16'h005A || fbits[0] != 16)
         begin errors++; $display("FAIL write_word got n=%0d word=%h required 1 frame 005A/16 bits", frames.size(), (frames.size() > 0) ? frames[0] : 16'hxxxx); end
      checks++;
      if (falls.size() < 1 || falls[0] != t0 + 1) begin errors++; $display("FAIL write_ss_fall got %0d required %0d", (falls.size() > 0) ? falls[0] : -1, t0 + 1); end
      checks++;
      if (rises.size() < 1 || falls.size() < 1 || rises[0] - falls[0] != 33 * C)
         begin errors++; $display("FAIL write_ss_low_len got %0d required %0d", (rises.size() > 0 && falls.size() > 0) ? rises[0] - falls[0] : -1, 33 * C); end
      checks++;
      if (rsp_cyc != t0 + 1 + 33 * C) begin errors++; $display("FAIL write_rsp_time got %0d required %0d", rsp_cyc, t0 + 1 + 33 * C); end
      checks++;
      if (rsp_cnt - c0 != 1) begin errors++; $display("FAIL write_rsp_pulses got %0d required 1", rsp_cnt - c0); end
      checks++;
      if (rc != t0 + 33 * C + G) begin errors++; $display("FAIL write_ready_return got %0d required %0d", rc, t0 + 33 * C + G); end
      checks++;
      if ({rsp_data, rsp_sync} !== {8'h12, 1'b1}) begin errors++; $display("FAIL write_rsp got %h/%b required 12/1", rsp_data, rsp_sync); end
   endtask

   task automatic test_read;
      int t0, rc, c0;
      reply = 16'hEE3C;
      frames.delete(); fbits.delete();
      c0 = rsp_cnt;
      send(3'd5, 8'h00, t0);
      wait_done(c0, rc);
      checks++;
      if (frames.size() != 1 || frames[0] !== 16'h0500)
         begin errors++; $display("FAIL read_word got %h required 0500", (frames.size() > 0) ? frames[0] : 16'hxxxx); end
      checks++;
      if ({rsp_data, rsp_sync} !== {8'h3C, 1'b1}) begin errors++; $display("FAIL read_rsp got %h/%b required 3c/1", rsp_data, rsp_sync); end
   endtask

   task automatic test_dead_link;
      int t0, rc, c0;
      reply = 16'hFFFF;
      c0 = rsp_cnt;
      send(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), t0);
      wait_done(c0, rc);
      checks++;
      if ({rsp_data, rsp_sync} !== {8'hFF, 1'b0}) begin errors++; $display("FAIL dead_rsp got %h/%b required ff/0", rsp_data, rsp_sync); end
   endtask

   task automatic test_random;
      int t0, rc, c0, r, d, hi, lo, exp_word;
      for (int i = 0; i < 6; i++) begin
         r  = $urandom_range(0, 7);
         d  = $urandom_range(0, 255);
         hi = ($urandom_range(0, 1) == 1) ? 238 : $urandom_range(0, 255);
         lo = $urandom_range(0, 255);
         reply = 16'(hi * 256 + lo);
         exp_word = r * 256 + d;
         frames.delete();
         c0 = rsp_cnt;
         send(3'(r), 8'(d), t0);
         wait_done(c0, rc);
         checks++;
         if (frames.size() != 1 || int'(frames[0]) != exp_word)
            begin errors++; $display("FAIL rand_word[%0d] got %h required %h", i, (frames.size() > 0) ? frames[0] : 16'hxxxx, 16'(exp_word)); end
         checks++;
         if (int'(rsp_data) != lo || rsp_sync !== (hi == 238))
            begin errors++; $display("FAIL rand_rsp[%0d] got %h/%b required %h/%b", i, rsp_data, rsp_sync, 8'(lo), (hi == 238)); end
      end
   endtask

   task automatic test_back_to_back;
      logic [2:0] rr[3] = '{3'd1, 3'd2, 3'd3};
      logic [7:0] dd[3] = '{8'hAA, 8'h01, 8'h01};
      int t0s[3];
      int k, c0, rc;
      reply = 16'hEE00;
      frames.delete(); falls.delete(); rises.delete();
      c0 = rsp_cnt;
      @(negedge clk);
      cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cmd_reg = rr[i]; cmd_data = dd[i];
         k = 0;
         while (cmd_ready !== 1'b1 && k < 400) begin @(negedge clk); k++; end
         if (k >= 400) begin checks++; errors++; $display("FAIL b2b_accept_timeout[%0d] ready=%b required 1", i, cmd_ready); end
         t0s[i] = cyc + 1;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      k = 0;
      while (rsp_cnt < c0 + 3 && k < 2000) begin @(negedge clk); k++; end
      wait_done(c0 + 2, rc);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (frames.size() != 3 || int'(frames[i]) != int'(rr[i]) * 256 + int'(dd[i]))
            begin errors++; $display("FAIL b2b_word[%0d] got %h required %h", i, (frames.size() > i) ? frames[i] : 16'hxxxx, {5'b0, rr[i], dd[i]}); end
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (falls.size() != 3 || rises.size() != 3 || falls[i + 1] - rises[i] != G + 1)
            begin errors++; $display("FAIL b2b_gap[%0d] got %0d required %0d", i, (falls.size() == 3 && rises.size() == 3) ? falls[i + 1] - rises[i] : -1, G + 1); end
         checks++;
         if (t0s[i + 1] - t0s[i] != 1 + 33 * C + G)
            begin errors++; $display("FAIL b2b_accept_spacing[%0d] got %0d required %0d", i, t0s[i + 1] - t0s[i], 1 + 33 * C + G); end
      end
   endtask

   task automatic test_protocol;
      checks++;
      if (viol != 0) begin errors++; $display("FAIL pin_protocol violations got %0d required 0", viol); end
   endtask

   task automatic test_reset_mid;
      int t0, k, c0, nf;
      reply = 16'hEE55;
      send(3'd2, 8'h33, t0);
      k = 0;
      while (cyc < t0 + 56 && k < 200) begin @(negedge clk); k++; end
      checks++;
      if ({sck, ss_n} !== 2'b10) begin errors++; $display("FAIL rmid_pre got sck/ss_n=%b required 10", {sck, ss_n}); end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({sck, ss_n} !== 2'b01) begin errors++; $display("FAIL rmid_async got sck/ss_n=%b required 01", {sck, ss_n}); end
      @(negedge clk);
      checks++;
      if ({cmd_ready, busy, rsp_valid} !== 3'b000) begin errors++; $display("FAIL rmid_held got ready/busy/vld=%b required 000", {cmd_ready, busy, rsp_valid}); end
      @(negedge clk);
      rst = 1'b0;
      nf = falls.size();
      c0 = rsp_cnt;
      @(negedge clk);
      checks++;
      if ({cmd_ready, busy} !== 2'b10) begin errors++; $display("FAIL rmid_idle got ready/busy=%b required 10", {cmd_ready, busy}); end
      repeat (150) @(negedge clk);
      checks++;
      if (rsp_cnt != c0 || falls.size() != nf)
         begin errors++; $display("FAIL rmid_quiet got rsp=%0d frames=%0d required 0/0", rsp_cnt - c0, falls.size() - nf); end
   endtask

   task automatic test_clkdiv2;
      int t0, k, c0;
      reply2 = 16'hEEC3;
      sck2_rises.delete();
      c0 = rsp_cnt2;
      @(negedge clk);
      cmd_reg2 = 3'd0; cmd_data2 = 8'h77; cmd_valid2 = 1'b1;
      k = 0;
      while (cmd_ready2 !== 1'b1 && k < 400) begin @(negedge clk); k++; end
      if (k >= 400) begin checks++; errors++; $display("FAIL div2_accept_timeout ready=%b required 1", cmd_ready2); end
      t0 = cyc + 1;
      @(negedge clk);
      cmd_valid2 = 1'b0;
      k = 0;
      while (rsp_cnt2 == c0 && k < 500) begin @(negedge clk); k++; end
      if (k >= 500) begin checks++; errors++; $display("FAIL div2_rsp_timeout rsp_cnt=%0d required >%0d", rsp_cnt2, c0); end
      checks++;
      if (rx2_done !== 16'h0077 || nb2_done != 16) begin errors++; $display("FAIL div2_word got %h/%0d required 0077/16", rx2_done, nb2_done); end
      checks++;
      if (sck2_rises.size() < 2 || sck2_rises[0] != t0 + 1 + C2 || sck2_rises[1] - sck2_rises[0] != 2 * C2)
         begin errors++; $display("FAIL div2_sck got first=%0d period=%0d required %0d/%0d", (sck2_rises.size() > 0) ? sck2_rises[0] : -1,
                                  (sck2_rises.size() > 1) ? sck2_rises[1] - sck2_rises[0] : -1, t0 + 1 + C2, 2 * C2); end
      checks++;
      if (rsp_cyc2 != t0 + 67 || rise2 - fall2 != 33 * C2)
         begin errors++; $display("FAIL div2_timing got rsp=%0d low=%0d required %0d/%0d", rsp_cyc2, rise2 - fall2, t0 + 67, 33 * C2); end
      checks++;
      if ({rsp_data2, rsp_sync2} !== {8'hC3, 1'b1}) begin errors++; $display("FAIL div2_rsp got %h/%b required c3/1", rsp_data2, rsp_sync2); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_dead_link();
      test_random();
      test_back_to_back();
      test_protocol();
      test_reset_mid();
      test_clkdiv2();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1);
   end
endmodule
